// File: rtl/pkt_fifo.sv
// Packet-aware store-and-forward FIFO. The reader only ever sees committed packets;
// the writer may abort its open packet, and packets larger than the storage are dropped.
module pkt_fifo #(
  parameter int DATA_WIDTH             = 32,
  parameter int DEPTH                  = 16,
  parameter int ALMOST_FULL_THRESHOLD  = DEPTH - 2,
  parameter int ALMOST_EMPTY_THRESHOLD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_WIDTH-1:0]    s_data,
  input  logic                     s_last,
  input  logic                     s_abort,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_last,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [$clog2(DEPTH):0]   pkt_count,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     drop_pulse,
  output logic [15:0]              drop_count
);
  // Handshake: a beat moves on a rising edge where valid & ready are both high.
  // Valid never waits on ready; s_ready is a register, m_valid is decoded from
  // registered pointers, so neither side sees a combinational path from the other.
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_WORDS = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);
  localparam logic [AW:0] AF_LEVEL   = (AW+1)'(ALMOST_FULL_THRESHOLD);
  localparam logic [AW:0] AE_LEVEL   = (AW+1)'(ALMOST_EMPTY_THRESHOLD);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_PKT  = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [AW:0]         wr_ptr;
  logic [AW:0]         commit_ptr;
  logic [AW:0]         rd_ptr;
  logic [AW:0]         wr_ptr_n;
  logic [AW:0]         commit_ptr_n;
  logic [AW:0]         rd_ptr_n;
  logic [AW:0]         committed_words;
  logic [DATA_WIDTH:0] mem [DEPTH];
  logic                wr_fire;
  logic                rd_fire;
  logic                mem_we;
  logic                commit;
  logic                drop;
  logic                oversize;
  logic                s_ready_n;

  assign occupancy       = wr_ptr - rd_ptr;
  assign committed_words = commit_ptr - rd_ptr;
  assign m_valid         = (rd_ptr != commit_ptr);
  assign {m_last, m_data} = mem[rd_ptr[AW-1:0]];
  assign almost_full     = (occupancy >= AF_LEVEL);
  assign almost_empty    = (committed_words <= AE_LEVEL);

  assign wr_fire  = s_valid & s_ready;
  assign rd_fire  = m_valid & m_ready;
  // Storage is full of one open packet: it can never be completed.
  assign oversize = (state == WR_PKT) && (occupancy == FULL_WORDS) && (committed_words == '0);

  always_comb begin
    state_n      = state;
    wr_ptr_n     = wr_ptr;
    commit_ptr_n = commit_ptr;
    mem_we       = 1'b0;
    commit       = 1'b0;
    drop         = 1'b0;
    unique case (state)
      IDLE, WR_PKT: begin
        if (oversize) begin
          wr_ptr_n = commit_ptr;
          drop     = 1'b1;
          state_n  = s_abort ? IDLE : DISCARD;
        end else if (s_abort) begin
          wr_ptr_n = commit_ptr;
          drop     = (state == WR_PKT) || s_valid;
          state_n  = IDLE;
        end else if (wr_fire) begin
          mem_we   = 1'b1;
          wr_ptr_n = wr_ptr + PTR_ONE;
          if (s_last) begin
            commit_ptr_n = wr_ptr + PTR_ONE;
            commit       = 1'b1;
            state_n      = IDLE;
          end else begin
            state_n = WR_PKT;
          end
        end
      end
      DISCARD: begin
        if (s_abort || (wr_fire && s_last)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign rd_ptr_n  = rd_fire ? rd_ptr + PTR_ONE : rd_ptr;
  // Computed from next-cycle pointers so the registered s_ready tracks occupancy exactly.
  assign s_ready_n = (state_n == DISCARD) || ((wr_ptr_n - rd_ptr_n) != FULL_WORDS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      pkt_count  <= '0;
      s_ready    <= 1'b1;
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_ptr_n;
      rd_ptr     <= rd_ptr_n;
      s_ready    <= s_ready_n;
      drop_pulse <= drop;
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      case ({commit, rd_fire & m_last})
        2'b10:   pkt_count <= pkt_count + PTR_ONE;
        2'b01:   pkt_count <= pkt_count - PTR_ONE;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr[AW-1:0]] <= {s_last, s_data};
  end

endmodule

// File: tb/tb_pkt_fifo.sv
// Bench for pkt_fifo: directed scenarios plus randomized packet traffic, checked
// against a packet-level model (committed packets queued beat by beat, drops counted).
module tb_pkt_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          s_valid, s_ready, s_last, s_abort;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
  logic [AW:0]   occupancy, pkt_count;
  logic          almost_full, almost_empty, drop_pulse;
  logic [15:0]   drop_count;

  pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_abort(s_abort),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .occupancy(occupancy), .pkt_count(pkt_count),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .drop_pulse(drop_pulse), .drop_count(drop_count)
  );

  int            tests_run    = 0;
  int            tests_failed = 0;
  logic [DW:0]   exp_q[$];
  int            exp_drops    = 0;
  int            drop_seen    = 0;
  int            max_pkt      = 0;
  int            ready_mode   = 0;  // 0: hold low, 1: hold high, 2: random
  logic          rnd_bit      = 1'b0;

  assign m_ready = (ready_mode == 2) ? rnd_bit : (ready_mode == 1);

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [DW:0] exp_beat;
    if (rst_n) begin
      if (drop_pulse) drop_seen++;
      if (int'(pkt_count) > max_pkt) max_pkt = int'(pkt_count);
      if (m_valid && m_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL read_unexpected: got data %0h last %0b, required no output", m_data, m_last);
        end else begin
          exp_beat = exp_q.pop_front();
          if ({m_last, m_data} !== exp_beat) begin
            tests_failed++;
            $display("FAIL read_beat: got last %0b data %0h, required last %0b data %0h",
                     m_last, m_data, exp_beat[DW], exp_beat[DW-1:0]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic last, output bit ok);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    ok      = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!ok) check("send_beat_timeout", 32'(ok), 32'd1);
  endtask

  task automatic do_abort(input logic with_valid);
    s_abort = 1'b1;
    s_valid = with_valid;
    s_data  = $urandom;
    s_last  = 1'b0;
    @(posedge clk);
    #1;
    s_abort = 1'b0;
    s_valid = 1'b0;
  endtask

  // Reference model: a packet shows up only if it completes and fits in DEPTH beats.
  task automatic send_pkt(input int len, input int abort_after);
    logic [DW:0]   beats[$];
    logic [DW-1:0] d;
    logic          last;
    bit            ok;
    for (int i = 0; i < len; i++) begin
      if (abort_after != 0 && i == abort_after) begin
        do_abort(1'b0);
        exp_drops++;
        return;
      end
      d    = $urandom;
      last = (i == len - 1);
      send_beat(d, last, ok);
      beats.push_back({last, d});
    end
    if (len > DEPTH) exp_drops++;
    else foreach (beats[k]) exp_q.push_back(beats[k]);
  endtask

  task automatic drain(input string name);
    int t = 0;
    ready_mode = 1;
    while ((exp_q.size() != 0 || m_valid) && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check({name, "_drain_done"}, 32'(t < 2000), 32'd1);
    wait_cycles(2);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    bit            ok;
    logic [DW:0]   a_beats[$];
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_abort = 1'b0;
    ready_mode = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles(1);

    // reset state
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_almost_empty", 32'(almost_empty), 32'd1);
    check("rst_almost_full", 32'(almost_full), 32'd0);
    check("rst_drop_pulse", 32'(drop_pulse), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);

    // asynchronous reset with three beats open
    for (int i = 0; i < 3; i++) send_beat($urandom, 1'b0, ok);
    check("midpkt_occupancy", 32'(occupancy), 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_occupancy", 32'(occupancy), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd1);
    check("midrst_drop_count", 32'(drop_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles(1);

    // basic 3-beat packet, visibility one cycle after the last beat
    ready_mode = 1;
    send_beat(32'hA1, 1'b0, ok); a_beats.push_back({1'b0, 32'hA1});
    send_beat(32'hA2, 1'b0, ok); a_beats.push_back({1'b0, 32'hA2});
    check("basic_not_visible_open", 32'(m_valid), 32'd0);
    send_beat(32'hA3, 1'b1, ok); a_beats.push_back({1'b1, 32'hA3});
    foreach (a_beats[k]) exp_q.push_back(a_beats[k]);
    @(negedge clk);
    check("basic_m_valid_latency", 32'(m_valid), 32'd1);
    check("basic_pkt_count_one", 32'(pkt_count), 32'd1);
    drain("basic");
    check("basic_pkt_count_zero", 32'(pkt_count), 32'd0);
    check("basic_occupancy", 32'(occupancy), 32'd0);

    // abort of an open packet
    send_beat($urandom, 1'b0, ok);
    send_beat($urandom, 1'b0, ok);
    check("abort_open_hidden", 32'(m_valid), 32'd0);
    do_abort(1'b0);
    exp_drops++;
    @(negedge clk);
    check("abort_occupancy", 32'(occupancy), 32'd0);
    check("abort_m_valid", 32'(m_valid), 32'd0);
    check("abort_drop_pulse", 32'(drop_pulse), 32'd1);
    @(negedge clk);
    check("abort_drop_pulse_once", 32'(drop_pulse), 32'd0);
    check("abort_drop_count", 32'(drop_count), 32'd1);
    @(posedge clk);
    #1;
    do_abort(1'b0);
    wait_cycles(1);
    check("abort_idle_no_effect", 32'(drop_count), 32'd1);
    do_abort(1'b1);
    exp_drops++;
    wait_cycles(1);
    check("abort_idle_valid_drop", 32'(drop_count), 32'd2);
    send_pkt(4, 0);
    drain("abort_b");

    // oversize packet with the reader stalled
    ready_mode = 0;
    for (int i = 1; i <= 20; i++) begin
      send_beat($urandom, 1'b0 | (i == 20), ok);
      if (i == 16) begin
        check("oversize_full_occ", 32'(occupancy), 32'd16);
        check("oversize_full_ready", 32'(s_ready), 32'd0);
      end
      if (i == 17) begin
        check("oversize_drop_count", 32'(drop_count), 32'(exp_drops + 1));
        check("oversize_rewound", 32'(occupancy), 32'd0);
      end
    end
    exp_drops++;
    wait_cycles(2);
    check("oversize_m_valid", 32'(m_valid), 32'd0);
    check("oversize_occupancy", 32'(occupancy), 32'd0);
    check("oversize_drop_total", 32'(drop_count), 32'(exp_drops));

    // back-pressure: two committed 8-beat packets fill the storage
    send_pkt(8, 0);
    send_pkt(8, 0);
    @(negedge clk);
    check("bp_occupancy", 32'(occupancy), 32'd16);
    check("bp_s_ready", 32'(s_ready), 32'd0);
    check("bp_almost_full", 32'(almost_full), 32'd1);
    check("bp_pkt_count", 32'(pkt_count), 32'd2);
    check("bp_almost_empty", 32'(almost_empty), 32'd0);
    @(posedge clk);
    #1;
    ready_mode = 1;
    @(negedge clk);
    check("bp_ready_same_cycle", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    ready_mode = 0;
    check("bp_ready_next_cycle", 32'(s_ready), 32'd1);
    check("bp_occupancy_after", 32'(occupancy), 32'd15);
    drain("bp");

    // interleaved 1- and 3-beat packets with random reader stalls, crossing the wrap
    ready_mode = 2;
    for (int p = 0; p < 40; p++) send_pkt((p % 2 == 1) ? 3 : 1, 0);
    drain("interleave");
    check("interleave_pkt_count", 32'(pkt_count), 32'd0);

    // random lengths, including oversize packets and random aborts
    ready_mode = 2;
    for (int p = 0; p < 40; p++) begin
      int len;
      int ab;
      len = $urandom_range(1, 20);
      ab  = 0;
      if (len > 1 && len <= DEPTH && $urandom_range(0, 5) == 0) ab = $urandom_range(1, len - 1);
      send_pkt(len, ab);
    end
    drain("random");

    check("final_pkt_count", 32'(pkt_count), 32'd0);
    check("final_occupancy", 32'(occupancy), 32'd0);
    check("final_drop_count", 32'(drop_count), 32'(exp_drops));
    check("final_drop_pulses", 32'(drop_seen), 32'(exp_drops));
    check("final_pkt_count_max", 32'(max_pkt <= DEPTH), 32'd1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
